pe_requant_stage: RTL and testbench



---
 rtl/pe_pkg.sv | 45 ++++
 rtl/pe_requant_stage_if.sv | 25 ++
 rtl/pe_requant_lane.sv | 36 +++
 rtl/pe_requant_stage.sv | 89 ++++++++
 tb/tb_pe_requant_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared constants, types and the saturation helper for the PE requant stage.
// Optional feature macro: PE_REQUANT_ROUND_EN (round-half-up before the shift).
package pe_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int ACC_WIDTH    = 32;
  localparam int VECTOR_WIDTH = 32;
  localparam int SHIFT_WIDTH  = 5;

  // Lane slicing helpers
  localparam int SUM_W      = ACC_WIDTH + 1;
  localparam int ACC_BUS_W  = VECTOR_WIDTH * ACC_WIDTH;
  localparam int DATA_BUS_W = VECTOR_WIDTH * DATA_WIDTH;
`ifdef PE_REQUANT_ROUND_EN
  localparam int RQ_W = ACC_WIDTH + 2;
`else
  localparam int RQ_W = ACC_WIDTH + 1;
`endif

  typedef logic [VECTOR_WIDTH-1:0][ACC_WIDTH-1:0]  acc_vec_t;
  typedef logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0] data_vec_t;

  typedef struct packed {
    logic [VECTOR_WIDTH-1:0][SUM_W-1:0] sum;
    logic [SHIFT_WIDTH-1:0]             shift;
  } s1_t;

  typedef struct packed {
    logic                  sat;
    logic [DATA_WIDTH-1:0] data;
  } sat_res_t;

  function automatic sat_res_t sat_to_data(input logic signed [RQ_W-1:0] v);
    logic signed [RQ_W-1:0] hi;
    logic signed [RQ_W-1:0] lo;
    sat_res_t               res;
    hi = {{(RQ_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      res = '{sat: 1'b1, data: {1'b0, {(DATA_WIDTH-1){1'b1}}}};
    else if (v < lo) res = '{sat: 1'b1, data: {1'b1, {(DATA_WIDTH-1){1'b0}}}};
    else             res = '{sat: 1'b0, data: v[DATA_WIDTH-1:0]};
    return res;
  endfunction

endpackage

// File: rtl/pe_requant_stage_if.sv
// Beat bus between the MAC array, the requant stage and the activation unit.
interface pe_requant_stage_if;
  import pe_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [ACC_BUS_W-1:0]    acc_i;
  logic [ACC_BUS_W-1:0]    bias_i;
  logic [SHIFT_WIDTH-1:0]  shift_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_BUS_W-1:0]   out_data;
  logic [VECTOR_WIDTH-1:0] out_sat;

  modport slave (
    input  in_valid, acc_i, bias_i, shift_i, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, acc_i, bias_i, shift_i, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/pe_requant_lane.sv
// Single-lane round / arithmetic shift / saturate, purely combinational.
// Optional feature macro: PE_REQUANT_ROUND_EN.
module pe_requant_lane
  import pe_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum,
  input  logic [SHIFT_WIDTH-1:0]  shift,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    sat
);

  logic signed [RQ_W-1:0] r;
  logic signed [RQ_W-1:0] sh;
  sat_res_t               res;

`ifdef PE_REQUANT_ROUND_EN
  logic [RQ_W-1:0] rnd;

  // Half an output LSB, so the truncating shift becomes round-half-up
  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = RQ_W'(1) << (shift - SHIFT_WIDTH'(1));
  end

  assign r = $signed({sum[SUM_W-1], sum}) + $signed(rnd);
`else
  assign r = sum;
`endif

  // Shifts past the width sign-fill to 0 / -1
  assign sh  = r >>> shift;
  assign res = sat_to_data(sh);
  assign q   = res.data;
  assign sat = res.sat;

endmodule

// File: rtl/pe_requant_stage.sv
// Two-stage valid/ready requant pipeline: S1 = acc + bias, S2 = round/shift/saturate.
// Optional feature macro: PE_REQUANT_ROUND_EN.
module pe_requant_stage
  import pe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  pe_requant_stage_if.slave  bus,
  output logic [31:0]        sat_count
);

  localparam int STAGES = 2;

  logic [STAGES:1]   vld_pipe;
  logic              s2_adv;
  logic              accept;
  acc_vec_t          acc;
  acc_vec_t          bias;
  s1_t               s1_d;
  s1_t               s1_q;
  data_vec_t         q_d;
  data_vec_t         q_q;
  logic [VECTOR_WIDTH-1:0] sat_d;
  logic [VECTOR_WIDTH-1:0] sat_q;

  assign acc  = bus.acc_i;
  assign bias = bus.bias_i;

  // S2 frees up when empty or being drained; S1 follows the same advance
  assign s2_adv       = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = !clear && (!vld_pipe[1] || s2_adv);
  assign accept       = bus.in_valid && bus.in_ready;

  // Sign-extended per-lane sum, one bit wider so it never overflows
  always_comb begin
    s1_d       = '0;
    s1_d.shift = bus.shift_i;
    for (int i = 0; i < VECTOR_WIDTH; i++)
      s1_d.sum[i] = {acc[i][ACC_WIDTH-1], acc[i]} + {bias[i][ACC_WIDTH-1], bias[i]};
  end

  // Valid bits: clear flushes both stages and wins over a new beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else if (clear) vld_pipe <= '0;
    else begin
      if (s2_adv)       vld_pipe[2] <= vld_pipe[1];
      if (bus.in_ready) vld_pipe[1] <= bus.in_valid;
    end
  end

  // S1 data, captured only on a real input transfer
  always_ff @(posedge clk) begin
    if (accept) s1_q <= s1_d;
  end

  for (genvar g = 0; g < VECTOR_WIDTH; g++) begin : g_lane
    pe_requant_lane u_lane (
      .sum   (s1_q.sum[g]),
      .shift (s1_q.shift),
      .q     (q_d[g]),
      .sat   (sat_d[g])
    );
  end

  // S2 data; reset so the output bus reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      sat_q <= '0;
    end else if (s2_adv && vld_pipe[1] && !clear) begin
      q_q   <= q_d;
      sat_q <= sat_d;
    end
  end

  // Counts delivered beats with at least one saturated lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (!clear && vld_pipe[2] && bus.out_ready && (|sat_q))
      sat_count <= sat_count + 32'd1;
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_data  = q_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_pe_requant_stage.sv
// Directed bench for pe_requant_stage; expectations follow PE_REQUANT_ROUND_EN.
module tb_pe_requant_stage;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] sat_count;
  int          checks   = 0;
  int          failures = 0;

  pe_requant_stage_if bus();

  pe_requant_stage u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (bus),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  logic [31:0] t_acc  [7] = '{32'h7FFF0000, 32'hFFFF0000, 32'h00001000, 32'hFFFFFE80,
                              32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] t_bias [7] = '{32'h00010000, 32'h0, 32'hFFFFF800, 32'h0,
                              32'h0, 32'h80000000, 32'h7FFFFFFF};
  logic [4:0]  t_sh   [7] = '{5'd0, 5'd0, 5'd4, 5'd8, 5'd31, 5'd16, 5'd17};
`ifdef PE_REQUANT_ROUND_EN
  logic [15:0] t_exp  [7] = '{16'h7FFF, 16'h8000, 16'h0080, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
  logic        t_sat  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] e_t1       = 16'h0002;
  logic [31:0] e_cnt      = 32'd4;
`else
  logic [15:0] t_exp  [7] = '{16'h7FFF, 16'h8000, 16'h0080, 16'hFFFE, 16'hFFFF, 16'h8000, 16'h7FFF};
  logic        t_sat  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] e_t1       = 16'h0001;
  logic [31:0] e_cnt      = 32'd3;
`endif

  logic [DATA_BUS_W-1:0] lane_exp;

  task automatic chk(input string tag, input logic [DATA_BUS_W-1:0] obs, input logic [DATA_BUS_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_BUS_W-1:0] rep(input logic [15:0] v);
    logic [DATA_BUS_W-1:0] r;
    for (int i = 0; i < VECTOR_WIDTH; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      bus.acc_i[i*ACC_WIDTH +: ACC_WIDTH]  = a;
      bus.bias_i[i*ACC_WIDTH +: ACC_WIDTH] = b;
    end
    bus.shift_i  = s;
    bus.in_valid = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.acc_i     = '0;
    bus.bias_i    = '0;
    bus.shift_i   = '0;
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_out_sat",   bus.out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // first beat latency and rounding
    drive(32'h00000180, 32'h0, 5'd8);
    step();
    bus.in_valid = 1'b0;
    chk("lat_edge1_valid", bus.out_valid, 0);
    step();
    chk("lat_edge2_valid", bus.out_valid, 1);
    chk("lat_data", bus.out_data, rep(e_t1));
    chk("lat_sat",  bus.out_sat, 0);
    step();
    chk("lat_drain", bus.out_valid, 0);

    // back-to-back stream: saturation, negative rounding, wide shifts, 33-bit sum
    for (int k = 0; k <= 7; k++) begin
      if (k < 7) drive(t_acc[k], t_bias[k], t_sh[k]);
      else       bus.in_valid = 1'b0;
      step();
      if (k >= 1) begin
        chk($sformatf("stream%0d_valid", k-1), bus.out_valid, 1);
        chk($sformatf("stream%0d_data", k-1),  bus.out_data, rep(t_exp[k-1]));
        chk($sformatf("stream%0d_sat", k-1),   bus.out_sat, {VECTOR_WIDTH{t_sat[k-1]}});
      end
    end
    step();
    chk("stream_drain", bus.out_valid, 0);
    chk("stream_sat_count", sat_count, e_cnt);

    // distinct lanes to check packing order
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      bus.acc_i[i*ACC_WIDTH +: ACC_WIDTH]     = 32'(i*256 - 4000);
      bus.bias_i[i*ACC_WIDTH +: ACC_WIDTH]    = 32'(i);
      lane_exp[i*DATA_WIDTH +: DATA_WIDTH]    = 16'(i*257 - 4000);
    end
    bus.shift_i  = 5'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("lane_order_data", bus.out_data, lane_exp);
    chk("lane_order_sat",  bus.out_sat, 0);
    step();

    // backpressure with A, B, C
    bus.out_ready = 1'b0;
    drive(32'h100, 32'h0, 5'd0);
    step();
    chk("stall_a_in_ready", bus.in_ready, 1);
    drive(32'h200, 32'h0, 5'd0);
    step();
    chk("stall_full_in_ready", bus.in_ready, 0);
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_data_a", bus.out_data, rep(16'h0100));
    drive(32'h300, 32'h0, 5'd0);
    step();
    chk("stall_hold_in_ready", bus.in_ready, 0);
    chk("stall_hold_data", bus.out_data, rep(16'h0100));
    bus.out_ready = 1'b1;
    #1;
    chk("stall_recover_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("stall_data_b", bus.out_data, rep(16'h0200));
    step();
    chk("stall_valid_c", bus.out_valid, 1);
    chk("stall_data_c", bus.out_data, rep(16'h0300));
    step();
    chk("stall_drain", bus.out_valid, 0);

    // clear with both stages full and a beat offered
    bus.out_ready = 1'b0;
    drive(t_acc[0], t_bias[0], 5'd0);
    step();
    drive(t_acc[1], t_bias[1], 5'd0);
    step();
    drive(32'h400, 32'h0, 5'd0);
    clear = 1'b1;
    #1;
    chk("clear_in_ready", bus.in_ready, 0);
    step();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    step();
    chk("clear_idle1", bus.out_valid, 0);
    step();
    chk("clear_idle2", bus.out_valid, 0);
    chk("clear_sat_count", sat_count, e_cnt);

    // asynchronous reset mid-stream
    drive(32'h500, 32'h0, 5'd0);
    step();
    drive(t_acc[0], t_bias[0], 5'd0);
    step();
    chk("mid_pre_valid", bus.out_valid, 1);
    chk("mid_pre_data", bus.out_data, rep(16'h0500));
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data",  bus.out_data, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", bus.out_valid, 0);
    drive(t_acc[0], t_bias[0], 5'd0);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_data", bus.out_data, rep(16'h7FFF));
    step();
    chk("post_rst_single", bus.out_valid, 0);
    step();
    chk("post_rst_idle2", bus.out_valid, 0);
    chk("post_rst_sat_count", sat_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
